// File: rtl/writeback_stage.sv
// Writeback stage: registers the register-file write for ALU, BL and load results,
// stalling upstream while a load waits for memory data, with a sticky timeout flag.
module writeback_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ValidM,
  input  logic        RegWriteM,
  input  logic        LinkM,
  input  logic        MemtoRegM,
  input  logic        ByteM,
  input  logic [3:0]  WA3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] ReadData,
  input  logic        DataReady,
  output logic [1:0]  RegWrite,
  output logic [3:0]  A3,
  output logic [31:0] WD3,
  output logic        BusyW,
  output logic        TimeoutErr
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_LINK = 2'b10;
  localparam logic [1:0] RW_A3   = 2'b11;

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]   reg_write_q, reg_write_d;
  logic [3:0]   a3_q, a3_d;
  logic [31:0]  wd3_q, wd3_d;
  logic         timeout_err_q, timeout_err_d;

  // Load instruction held while waiting for memory
  logic         cap_reg_write_q, cap_reg_write_d;
  logic         cap_byte_q, cap_byte_d;
  logic [3:0]   cap_wa3_q, cap_wa3_d;
  logic [1:0]   cap_lane_q, cap_lane_d;

  function automatic logic [31:0] load_data(input logic is_byte, input logic [1:0] lane,
                                            input logic [31:0] rd);
    logic [31:0] shifted;
    shifted = rd >> {lane, 3'b000};
    return is_byte ? {24'h0, shifted[7:0]} : rd;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d         = state_q;
    cnt_d           = cnt_q;
    reg_write_d     = RW_NONE;
    a3_d            = a3_q;
    wd3_d           = wd3_q;
    timeout_err_d   = timeout_err_q;
    cap_reg_write_d = cap_reg_write_q;
    cap_byte_d      = cap_byte_q;
    cap_wa3_d       = cap_wa3_q;
    cap_lane_d      = cap_lane_q;

    unique case (state_q)
      S_IDLE: begin
        if (ValidM) begin
          if (LinkM) begin
            reg_write_d = RW_LINK;
            a3_d        = 4'd14;
            wd3_d       = 32'h0;
          end else if (!MemtoRegM) begin
            reg_write_d = RegWriteM ? RW_A3 : RW_NONE;
            a3_d        = WA3M;
            wd3_d       = ALUResultM;
          end else if (DataReady) begin
            reg_write_d = RegWriteM ? RW_A3 : RW_NONE;
            a3_d        = WA3M;
            wd3_d       = load_data(ByteM, ALUResultM[1:0], ReadData);
          end else begin
            cap_reg_write_d = RegWriteM;
            cap_byte_d      = ByteM;
            cap_wa3_d       = WA3M;
            cap_lane_d      = ALUResultM[1:0];
            cnt_d           = '0;
            state_d         = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Data arriving on the last permitted cycle beats the timeout.
        if (DataReady) begin
          reg_write_d = cap_reg_write_q ? RW_A3 : RW_NONE;
          a3_d        = cap_wa3_q;
          wd3_d       = load_data(cap_byte_q, cap_lane_q, ReadData);
          state_d     = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      reg_write_q   <= RW_NONE;
      a3_q          <= 4'd0;
      wd3_q         <= 32'h0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      reg_write_q   <= reg_write_d;
      a3_q          <= a3_d;
      wd3_q         <= wd3_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // NOTE: capture registers need no reset; they are only read in S_WAIT, after being loaded.
  always_ff @(posedge clk) begin
    cap_reg_write_q <= cap_reg_write_d;
    cap_byte_q      <= cap_byte_d;
    cap_wa3_q       <= cap_wa3_d;
    cap_lane_q      <= cap_lane_d;
  end

  assign RegWrite   = reg_write_q;
  assign A3         = a3_q;
  assign WD3        = wd3_q;
  assign BusyW      = (state_q == S_WAIT);
  assign TimeoutErr = timeout_err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: stimulus queues expected writes,
// a negedge monitor compares every issued write and flags unexpected ones.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ValidM, RegWriteM, LinkM, MemtoRegM, ByteM;
  logic [3:0]  WA3M;
  logic [31:0] ALUResultM, ReadData;
  logic        DataReady;
  logic [1:0]  RegWrite;
  logic [3:0]  A3;
  logic [31:0] WD3;
  logic        BusyW, TimeoutErr;

  typedef struct {
    logic [1:0]  rw;
    logic [3:0]  a3;
    logic [31:0] wd;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  writeback_stage #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .ValidM(ValidM), .RegWriteM(RegWriteM), .LinkM(LinkM),
    .MemtoRegM(MemtoRegM), .ByteM(ByteM), .WA3M(WA3M), .ALUResultM(ALUResultM),
    .ReadData(ReadData), .DataReady(DataReady), .RegWrite(RegWrite), .A3(A3), .WD3(WD3),
    .BusyW(BusyW), .TimeoutErr(TimeoutErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_write(input logic [1:0] rw, input logic [3:0] a3, input logic [31:0] wd);
    wr_t e;
    e.rw = rw; e.a3 = a3; e.wd = wd;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    ValidM = 0; RegWriteM = 0; LinkM = 0; MemtoRegM = 0; ByteM = 0;
    WA3M = 4'd0; ALUResultM = 32'h0; DataReady = 0;
  endtask

  task automatic issue(input logic rw, input logic link, input logic m2r, input logic byt,
                       input logic [3:0] wa3, input logic [31:0] alu, input logic dr);
    ValidM = 1; RegWriteM = rw; LinkM = link; MemtoRegM = m2r; ByteM = byt;
    WA3M = wa3; ALUResultM = alu; DataReady = dr;
  endtask

  // Monitor: every cycle with a write must match the oldest queued expectation.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && RegWrite !== 2'b00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {26'h0, RegWrite, A3}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("wr_regwrite", {30'h0, RegWrite}, {30'h0, e.rw});
          check("wr_a3", {28'h0, A3}, {28'h0, e.a3});
          check("wr_wd3", WD3, e.wd);
        end
      end
    end
  end

  initial begin
    reset = 0;
    ReadData = 32'h0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    check("rst_regwrite", {30'h0, RegWrite}, 32'h0);
    check("rst_a3", {28'h0, A3}, 32'h0);
    check("rst_wd3", WD3, 32'h0);
    check("rst_busy", {31'h0, BusyW}, 32'h0);
    check("rst_terr", {31'h0, TimeoutErr}, 32'h0);
    reset = 1;
    @(negedge clk);

    // ALU op, then one-cycle pulse check
    issue(1, 0, 0, 0, 4'd3, 32'h12345678, 0);
    expect_write(2'b11, 4'd3, 32'h12345678);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    check("alu_one_cycle", {30'h0, RegWrite}, 32'h0);

    // ALU op without RegWriteM: no write
    issue(0, 0, 0, 0, 4'd4, 32'hDEADBEEF, 0);
    @(negedge clk);
    idle_inputs();
    check("alu_nowrite", {30'h0, RegWrite}, 32'h0);

    // BL: link overrides RegWriteM/MemtoRegM
    issue(1, 1, 1, 0, 4'd5, 32'h00000040, 0);
    expect_write(2'b10, 4'd14, 32'h0);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    check("bl_one_cycle", {30'h0, RegWrite}, 32'h0);

    // PC write passes straight through
    issue(1, 0, 0, 0, 4'd15, 32'h00001000, 0);
    expect_write(2'b11, 4'd15, 32'h00001000);
    @(negedge clk);

    // Word and byte loads with data ready immediately
    ReadData = 32'hAABBCCDD;
    issue(1, 0, 1, 0, 4'd6, 32'h00000200, 1);
    expect_write(2'b11, 4'd6, 32'hAABBCCDD);
    @(negedge clk);
    check("ld_word_busy", {31'h0, BusyW}, 32'h0);
    issue(1, 0, 1, 1, 4'd8, 32'h00000203, 1);
    expect_write(2'b11, 4'd8, 32'h000000AA);
    @(negedge clk);
    issue(1, 0, 1, 1, 4'd9, 32'h00000200, 1);
    expect_write(2'b11, 4'd9, 32'h000000DD);
    @(negedge clk);

    // LDRB lane 2 with three WAIT cycles; M inputs changed while waiting
    issue(1, 0, 1, 1, 4'd7, 32'h00000102, 0);
    @(negedge clk);
    check("ldrb_busy1", {31'h0, BusyW}, 32'h1);
    issue(1, 1, 0, 0, 4'd2, 32'hFFFFFFFF, 0);
    @(negedge clk);
    check("ldrb_busy2", {31'h0, BusyW}, 32'h1);
    @(negedge clk);
    check("ldrb_busy3", {31'h0, BusyW}, 32'h1);
    DataReady = 1;
    expect_write(2'b11, 4'd7, 32'h000000BB);
    @(negedge clk);
    idle_inputs();
    check("ldrb_done_busy", {31'h0, BusyW}, 32'h0);

    // Load with RegWriteM=0 waits but writes nothing
    issue(0, 0, 1, 0, 4'd10, 32'h0, 0);
    @(negedge clk);
    idle_inputs();
    check("ld_nowr_busy", {31'h0, BusyW}, 32'h1);
    DataReady = 1;
    @(negedge clk);
    DataReady = 0;
    check("ld_nowr_rw", {30'h0, RegWrite}, 32'h0);
    check("ld_nowr_idle", {31'h0, BusyW}, 32'h0);

    // Data on the 15th (last permitted) WAIT cycle wins over timeout
    ReadData = 32'h0BADF00D;
    issue(1, 0, 1, 0, 4'd11, 32'h0, 0);
    @(negedge clk);
    idle_inputs();
    for (int i = 1; i < 15; i++) @(negedge clk);
    check("last_cycle_busy", {31'h0, BusyW}, 32'h1);
    DataReady = 1;
    expect_write(2'b11, 4'd11, 32'h0BADF00D);
    @(negedge clk);
    DataReady = 0;
    check("last_cycle_terr", {31'h0, TimeoutErr}, 32'h0);
    check("last_cycle_idle", {31'h0, BusyW}, 32'h0);

    // Timeout after 15 WAIT cycles
    issue(1, 0, 1, 0, 4'd12, 32'h0, 0);
    @(negedge clk);
    idle_inputs();
    for (int i = 1; i < 15; i++) @(negedge clk);
    check("to_busy15", {31'h0, BusyW}, 32'h1);
    check("to_terr_early", {31'h0, TimeoutErr}, 32'h0);
    @(negedge clk);
    check("to_terr", {31'h0, TimeoutErr}, 32'h1);
    check("to_busy", {31'h0, BusyW}, 32'h0);
    check("to_rw", {30'h0, RegWrite}, 32'h0);
    DataReady = 1;
    @(negedge clk);
    DataReady = 0;
    issue(1, 0, 0, 0, 4'd1, 32'h00000055, 0);
    expect_write(2'b11, 4'd1, 32'h00000055);
    @(negedge clk);
    idle_inputs();
    check("to_sticky", {31'h0, TimeoutErr}, 32'h1);

    // Reset during WAIT abandons the load
    issue(1, 0, 1, 0, 4'd13, 32'h0, 0);
    @(negedge clk);
    idle_inputs();
    check("rw_busy", {31'h0, BusyW}, 32'h1);
    reset = 0;
    @(negedge clk);
    check("rw_busy_clr", {31'h0, BusyW}, 32'h0);
    check("rw_rw", {30'h0, RegWrite}, 32'h0);
    check("rw_terr_clr", {31'h0, TimeoutErr}, 32'h0);
    reset = 1;
    DataReady = 1;
    @(negedge clk);
    check("rw_nowrite", {30'h0, RegWrite}, 32'h0);
    DataReady = 0;
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum WAIT cycles allowed for load data before abort.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-low; sampled on posedge clk.
REQ-004 ValidM  in  1  memory-stage instruction valid; accepted only when BusyW=0.
REQ-005 RegWriteM  in  1  instruction writes a register.
REQ-006 LinkM  in  1  BL instruction: link write (R14 and R15).
REQ-007 MemtoRegM  in  1  result comes from load data.
REQ-008 ByteM  in  1  byte load (LDRB); otherwise word.
REQ-009 WA3M  in  4  destination register index.
REQ-010 ALUResultM  in  32  ALU result; bits [1:0] give the byte lane for loads.
REQ-011 ReadData  in  32  data-memory read word.
REQ-012 DataReady  in  1  ReadData valid this cycle.
REQ-013 RegWrite  out  2  register-file write code: 11 write A3, 10 link, 00 none.
REQ-014 A3  out  4  write address to register file.
REQ-015 WD3  out  32  write data to register file.
REQ-016 BusyW  out  1  stage busy; upstream holds its outputs stable while 1.
REQ-017 TimeoutErr  out  1  sticky load-timeout flag.

Function
REQ-018 All outputs SHALL be registered and change only on posedge clk, stable at the register file's negedge write.
REQ-019 FSM states SHALL be IDLE and WAIT; BusyW=1 exactly while in WAIT.
REQ-020 IDLE, ValidM=0: RegWrite=00 next cycle, stay IDLE.
REQ-021 IDLE, ValidM=1, LinkM=1: RegWrite=10, A3=14, WD3=0 next cycle; LinkM overrides RegWriteM and MemtoRegM; no memory wait.
REQ-022 IDLE, ValidM=1, LinkM=0, MemtoRegM=0: RegWrite=(RegWriteM ? 11 : 00), A3=WA3M, WD3=ALUResultM next cycle.
REQ-023 IDLE, ValidM=1, load (MemtoRegM=1, LinkM=0), DataReady=1: write issued next cycle with load data, stay IDLE.
REQ-024 IDLE, load, DataReady=0: capture RegWriteM, ByteM, WA3M, ALUResultM[1:0]; go WAIT; clear wait counter; RegWrite=00.
REQ-025 WAIT: ValidM and all M-stage inputs ignored; captured values used.
REQ-026 WAIT, DataReady=1: write issued next cycle with load data, return IDLE.
REQ-027 WAIT, DataReady=0: counter increments; when TIMEOUT consecutive WAIT cycles elapse without DataReady, set TimeoutErr=1, RegWrite=00, return IDLE, instruction dropped.
REQ-028 DataReady=1 on the final permitted WAIT cycle SHALL win over timeout.
REQ-029 Load data: word -> ReadData; byte -> ReadData[8*lane+7:8*lane] zero-extended to 32 bits, lane=ALUResultM[1:0].
REQ-030 Load with RegWriteM=0 SHALL still wait for DataReady but issue RegWrite=00.
REQ-031 Any issued RegWrite 11/10 SHALL last exactly one cycle; RegWrite=00 otherwise.
REQ-032 WA3M=15 with RegWrite=11 SHALL be passed through unchanged (PC write).
REQ-033 TimeoutErr SHALL clear only on reset.

Reset
REQ-034 reset=0 at posedge: state IDLE, counter 0, RegWrite=00, A3=0, WD3=0, BusyW=0, TimeoutErr=0.
REQ-035 reset asserted in WAIT SHALL abandon the pending load with no write issued.

Verification
REQ-036 ALU op: ValidM=1, RegWriteM=1, WA3M=3, ALUResultM=0x12345678 -> next cycle RegWrite=11, A3=3, WD3=0x12345678; following cycle RegWrite=00.
REQ-037 BL: ValidM=1, LinkM=1, RegWriteM=1, WA3M=5 -> RegWrite=10, A3=14 for one cycle.
REQ-038 LDRB: ALUResultM=0x102, ReadData=0xAABBCCDD, DataReady=1 after 3 WAIT cycles -> BusyW=1 for 3 cycles, then RegWrite=11, WD3=0x000000BB.
REQ-039 Timeout: load, DataReady held 0 -> after 15 WAIT cycles TimeoutErr=1, RegWrite stays 00, BusyW=0; TimeoutErr persists until reset.
REQ-040 reset=0 during WAIT -> next cycle BusyW=0, RegWrite=00; later DataReady=1 produces no write.
